// File: rtl/edge_detection_pkg.sv
// Shared types and default geometry for the edge-detection line-buffer controller.
package edge_detection_pkg;

  localparam int unsigned DEF_H_PIXELS = 640;
  localparam int unsigned DEF_V_LINES  = 480;
  localparam int unsigned DEF_X_W      = $clog2(DEF_H_PIXELS);
  localparam int unsigned DEF_Y_W      = $clog2(DEF_V_LINES);

  typedef logic [1:0] buf_sel_t;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    FILL,
    RUN,
    DONE
  } lbc_state_t;

  // Modulo-3 add for the rotating buffer index; both operands are in 0..2.
  function automatic buf_sel_t sel_add(input buf_sel_t s, input logic [1:0] n);
    logic [2:0] t;
    t = {1'b0, s} + {1'b0, n};
    return (t >= 3'd3) ? buf_sel_t'(t - 3'd3) : buf_sel_t'(t);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Remembers last-cycle VSYNC/DE and flags the VSYNC assertion edge and the DE falling edge
// combinationally against the current sample, so the top level can register its outputs once.
module sync_edge_det #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vsync_i,
  input  logic de_i,
  output logic vs_rise_o,
  output logic de_fall_o
);

  logic vs_act;
  logic vs_act_q;
  logic de_q;

  assign vs_act = SYNC_ACTIVE_LOW ? ~vsync_i : vsync_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_act_q <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      vs_act_q <= vs_act;
      de_q     <= de_i;
    end
  end

  assign vs_rise_o = vs_act & ~vs_act_q;
  assign de_fall_o = ~de_i & de_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer for the 3x3 Sobel window: frame/line tracking, write addressing,
// buffer rotation and framing errors. Optional stats ports under LBC_FRAME_STATS_EN.
module line_buffer_ctrl
  import edge_detection_pkg::*;
#(
  parameter int unsigned H_PIXELS        = DEF_H_PIXELS,
  parameter int unsigned V_LINES         = DEF_V_LINES,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  localparam int unsigned X_W            = $clog2(H_PIXELS + 1),
  localparam int unsigned Y_W            = $clog2(V_LINES + 1)
) (
  input  logic           I_PCLK,
  input  logic           I_RST,
  input  logic           I_VSYNC,
  input  logic           I_DE,
  input  logic           I_ERR_CLR,
  output logic           O_WR_EN,
  output buf_sel_t       O_WR_SEL,
  output logic [X_W-1:0] O_WR_ADDR,
  output buf_sel_t       O_TOP_SEL,
  output buf_sel_t       O_MID_SEL,
  output logic           O_WIN_VALID,
  output logic [Y_W-1:0] O_Y,
  output logic           O_FRAME_ST,
  output logic           O_ERR
`ifdef LBC_FRAME_STATS_EN
  ,
  output logic [15:0]    O_FRAME_CNT,
  output logic [Y_W-1:0] O_LAST_LINES
`endif
);

  // Counters carry one extra code so x can sit at H_PIXELS and y at V_LINES.
  localparam logic [X_W-1:0] X_END = X_W'(H_PIXELS);
  localparam logic [X_W-1:0] X_TWO = X_W'(2);
  localparam logic [Y_W-1:0] Y_END = Y_W'(V_LINES);
  localparam logic [Y_W-1:0] Y_TWO = Y_W'(2);

  logic vs_rise;
  logic de_fall;

  sync_edge_det #(
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_sync_edge_det (
    .clk_i    (I_PCLK),
    .rst_i    (I_RST),
    .vsync_i  (I_VSYNC),
    .de_i     (I_DE),
    .vs_rise_o(vs_rise),
    .de_fall_o(de_fall)
  );

  lbc_state_t     state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  buf_sel_t       sel_q, sel_d;
  buf_sel_t       top_q, top_d;
  buf_sel_t       mid_q, mid_d;
  logic [X_W-1:0] addr_q, addr_d;
  logic           wr_en_q, wr_en_d;
  logic           win_q, win_d;
  logic           fs_q, fs_d;
  logic           err_q, err_d;
  logic           err_set;
  logic           active;
  logic           line_end;
  logic [Y_W-1:0] y_inc;

  assign active   = (state_q == FILL) || (state_q == RUN);
  assign line_end = de_fall & active;
  assign y_inc    = y_q + Y_W'(1);

  always_ff @(posedge I_PCLK or posedge I_RST) begin
    if (I_RST) state_q <= WAIT_FRAME;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      state_d = FILL;
    end else if (line_end) begin
      if (y_inc == Y_END)      state_d = DONE;
      else if (y_inc >= Y_TWO) state_d = RUN;
    end
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    top_d   = top_q;
    mid_d   = mid_q;
    addr_d  = addr_q;
    wr_en_d = 1'b0;
    win_d   = 1'b0;
    fs_d    = 1'b0;
    err_set = 1'b0;
    if (vs_rise) begin
      fs_d    = 1'b1;
      x_d     = '0;
      y_d     = '0;
      sel_d   = 2'd0;
      top_d   = 2'd1;
      mid_d   = 2'd2;
      err_set = I_DE;
    end else if (active && I_DE) begin
      if (x_q < X_END) begin
        wr_en_d = 1'b1;
        addr_d  = x_q;
        x_d     = x_q + X_W'(1);
        win_d   = (y_q >= Y_TWO) && (x_q >= X_TWO);
      end else begin
        err_set = 1'b1;
      end
    end else if (line_end) begin
      // Rotation advances even on a malformed line so buffer roles stay in step with y.
      err_set = (x_q != X_END);
      x_d     = '0;
      y_d     = y_inc;
      sel_d   = sel_add(sel_q, 2'd1);
      top_d   = sel_add(sel_d, 2'd1);
      mid_d   = sel_add(sel_d, 2'd2);
    end else if ((state_q == DONE) && I_DE) begin
      err_set = 1'b1;
    end
    err_d = err_set | (err_q & ~I_ERR_CLR);
  end

  always_ff @(posedge I_PCLK or posedge I_RST) begin
    if (I_RST) begin
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= 2'd0;
      top_q   <= 2'd1;
      mid_q   <= 2'd2;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
      win_q   <= 1'b0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      addr_q  <= addr_d;
      wr_en_q <= wr_en_d;
      win_q   <= win_d;
      fs_q    <= fs_d;
      err_q   <= err_d;
    end
  end

  assign O_WR_EN     = wr_en_q;
  assign O_WR_SEL    = sel_q;
  assign O_WR_ADDR   = addr_q;
  assign O_TOP_SEL   = top_q;
  assign O_MID_SEL   = mid_q;
  assign O_WIN_VALID = win_q;
  assign O_Y         = y_q;
  assign O_FRAME_ST  = fs_q;
  assign O_ERR       = err_q;

`ifdef LBC_FRAME_STATS_EN
  logic [15:0]    frame_cnt_q;
  logic [Y_W-1:0] last_lines_q;

  // Only a VSYNC that closes a completed frame counts; every VSYNC snapshots the line count.
  always_ff @(posedge I_PCLK or posedge I_RST) begin
    if (I_RST) begin
      frame_cnt_q  <= '0;
      last_lines_q <= '0;
    end else if (vs_rise) begin
      if (state_q == DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
      last_lines_q <= y_q;
    end
  end

  assign O_FRAME_CNT  = frame_cnt_q;
  assign O_LAST_LINES = last_lines_q;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl on a 640-pixel, 6-line geometry; stats checks
// are compiled in when LBC_FRAME_STATS_EN is defined.
module tb_line_buffer_ctrl;
  import edge_detection_pkg::*;

  localparam int H  = 640;
  localparam int V  = 6;
  localparam int XW = $clog2(H + 1);
  localparam int YW = $clog2(V + 1);

  logic          clk = 1'b0;
  logic          rst, vsync, de, err_clr;
  logic          wr_en, win, fs, err;
  logic [1:0]    wr_sel, top_sel, mid_sel;
  logic [XW-1:0] wr_addr;
  logic [YW-1:0] oy;
`ifdef LBC_FRAME_STATS_EN
  logic [15:0]   frame_cnt;
  logic [YW-1:0] last_lines;
`endif

  always #20 clk = ~clk;

  line_buffer_ctrl #(
    .H_PIXELS(H),
    .V_LINES(V),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .I_PCLK(clk),
    .I_RST(rst),
    .I_VSYNC(vsync),
    .I_DE(de),
    .I_ERR_CLR(err_clr),
    .O_WR_EN(wr_en),
    .O_WR_SEL(wr_sel),
    .O_WR_ADDR(wr_addr),
    .O_TOP_SEL(top_sel),
    .O_MID_SEL(mid_sel),
    .O_WIN_VALID(win),
    .O_Y(oy),
    .O_FRAME_ST(fs),
    .O_ERR(err)
`ifdef LBC_FRAME_STATS_EN
    ,
    .O_FRAME_CNT(frame_cnt),
    .O_LAST_LINES(last_lines)
`endif
  );

  typedef struct packed {
    logic [XW-1:0] addr;
    logic [1:0]    sel;
    logic          win;
    logic [YW-1:0] y;
    logic [1:0]    top;
    logic [1:0]    mid;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  wr_exp_t mon_e;
  int checks = 0, errors = 0;
  int fs_count = 0, win_count = 0, wr_count = 0;
  int m_y = 0, m_sel = 0;
  bit m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expected write for every write the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      if (fs)  fs_count++;
      if (win) win_count++;
      if (wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d sel %0d y %0d, expected no write", wr_addr, wr_sel, oy);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("write y%0d x%0d {addr,sel,win,y,top,mid}", mon_e.y, mon_e.addr),
                32'({wr_addr, wr_sel, win, oy, top_sel, mid_sel}), 32'(mon_e));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input int x);
    wr_exp_t e;
    e.addr = XW'(x);
    e.sel  = 2'(m_sel);
    e.win  = (m_y >= 2) && (x >= 2);
    e.y    = YW'(m_y);
    e.top  = 2'((m_sel + 1) % 3);
    e.mid  = 2'((m_sel + 2) % 3);
    exp_q.push_back(e);
  endtask

  task automatic drive_line(input int n);
    for (int i = 0; i < n; i++) begin
      if (i < H) push_write(i);
      de = 1'b1;
      cyc();
    end
    de = 1'b0;
    repeat (4) cyc();
    if (n != H) m_err = 1'b1;
    m_y++;
    m_sel = (m_sel + 1) % 3;
  endtask

  task automatic vsync_edge();
    vsync = 1'b0;
    cyc();
    vsync = 1'b1;
    repeat (2) cyc();
    m_y = 0;
    m_sel = 0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    cyc();
    m_err = 1'b0;
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not reach its summary within the time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fs0, win0, wr0;
    rst = 1'b0; vsync = 1'b1; de = 1'b0; err_clr = 1'b0;
    #5 rst = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_sel", wr_sel, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_top_sel", top_sel, 1);
    check("rst_mid_sel", mid_sel, 2);
    check("rst_win_valid", win, 0);
    check("rst_y", oy, 0);
    check("rst_frame_st", fs, 0);
    check("rst_err", err, 0);
`ifdef LBC_FRAME_STATS_EN
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_last_lines", last_lines, 0);
`endif
    rst = 1'b0;
    cyc();

    // DE activity before the first VSYNC must be ignored.
    wr0 = wr_count;
    repeat (10) begin de = 1'b1; cyc(); end
    de = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    check("wait_frame_writes", wr_count - wr0, 0);
    check("wait_frame_err", err, 0);
    check("wait_frame_y", oy, 0);

    fs0 = fs_count;
    vsync_edge();
    check("first_vsync_frame_st", fs_count - fs0, 1);
    drive_line(H);
    drive_line(H);
    win0 = win_count;
    drive_line(H);
    @(negedge clk);
    check("line2_win_pulses", win_count - win0, 638);
    check("three_lines_err", err, m_err);
    check("three_lines_y", oy, m_y);
    check("after_line2_top", top_sel, 1);
    check("after_line2_mid", mid_sel, 2);

    // Long line: 640 writes, 5 dropped, error raised.
    wr0 = wr_count;
    drive_line(H + 5);
    @(negedge clk);
    check("long_line_writes", wr_count - wr0, H);
    check("long_line_err", err, m_err);
    clear_err();
    @(negedge clk);
    check("err_clr", err, m_err);
    drive_line(H);
    drive_line(H);
    @(negedge clk);
    check("frame_end_y", oy, V);
    check("frame_end_err", err, 0);

    // DONE: DE is an error and produces no writes; set beats clear in the same cycle.
    wr0 = wr_count;
    repeat (20) begin de = 1'b1; cyc(); end
    de = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    check("done_writes", wr_count - wr0, 0);
    check("done_de_err", err, 1);
    clear_err();
    de = 1'b1; err_clr = 1'b1;
    cyc();
    de = 1'b0; err_clr = 1'b0;
    cyc();
    @(negedge clk);
    check("set_beats_clear", err, 1);
    clear_err();
    @(negedge clk);
    check("done_err_cleared", err, 0);

    // New frame; VSYNC arrives at x=300 of line 2 while DE is high.
    fs0 = fs_count;
    vsync_edge();
`ifdef LBC_FRAME_STATS_EN
    @(negedge clk);
    check("stats_cnt_frame1", frame_cnt, 1);
    check("stats_last_frame1", last_lines, V);
`endif
    drive_line(H);
    drive_line(H);
    for (int i = 0; i < 300; i++) begin push_write(i); de = 1'b1; cyc(); end
    vsync = 1'b0;
    cyc();
    vsync = 1'b1;
    m_y = 0; m_sel = 0;
    for (int i = 0; i < 10; i++) begin push_write(i); cyc(); end
    de = 1'b0;
    repeat (4) cyc();
    m_err = 1'b1; m_y = 1; m_sel = 1;
    @(negedge clk);
    check("midline_vsync_frame_st", fs_count - fs0, 2);
    check("midline_vsync_err", err, m_err);
    check("midline_vsync_y", oy, m_y);
    check("midline_vsync_wr_sel", wr_sel, m_sel);
`ifdef LBC_FRAME_STATS_EN
    check("stats_cnt_midline", frame_cnt, 1);
    check("stats_last_midline", last_lines, 2);
`endif
    clear_err();
    for (int l = 1; l < V; l++) drive_line(H);
    vsync_edge();
    @(negedge clk);
    check("frame2_err", err, 0);
    check("new_frame_y", oy, 0);
    check("new_frame_top", top_sel, 1);
`ifdef LBC_FRAME_STATS_EN
    check("stats_cnt_frame2", frame_cnt, 2);
    check("stats_last_frame2", last_lines, V);
`endif

    // Reset in the middle of line 1 returns everything to reset values at once.
    drive_line(H);
    for (int i = 0; i < 5; i++) begin push_write(i); de = 1'b1; cyc(); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midline_rst_wr_en", wr_en, 0);
    check("midline_rst_addr", wr_addr, 0);
    check("midline_rst_y", oy, 0);
    check("midline_rst_wr_sel", wr_sel, 0);
    check("midline_rst_mid", mid_sel, 2);
    de = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    wr0 = wr_count;
    repeat (3) begin de = 1'b1; cyc(); end
    de = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check("post_rst_writes", wr_count - wr0, 0);
    check("exp_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
